// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    ACK,
    RUN,
    ERR
  } state_t;

  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam int         LEN_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word/word_done are valid
// combinationally in the cycle the 4th byte is presented.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST = 2'(LEN_BYTES - 1);

  logic [1:0]  cnt;
  logic [23:0] lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      lo  <= 24'd0;
    end else if (in_valid) begin
      cnt <= cnt + 2'd1;
      lo  <= {in_byte, lo[23:8]};
    end
  end

  assign word      = {in_byte, lo};
  assign word_done = in_valid && (cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed image over the UART, writes
// it to instruction memory, acknowledges, then hands the UART to the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_empty,
  input  logic [7:0]         uart_in,
  input  logic               uart_full,
  output logic               uart_rdreq,
  output logic               uart_wrreq,
  output logic [7:0]         uart_out,
  input  logic               cpu_uart_rdreq,
  input  logic               cpu_uart_wrreq,
  input  logic [7:0]         cpu_uart_out,
  output logic               cpu_uart_empty,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_run,
  output logic               load_err
);

  localparam logic [32:0] CAP = 33'(1) << IMEM_AW;

  state_t             state, state_n;
  logic               pend;
  logic               ld_rd, ld_wr;
  logic [7:0]         tx_byte;
  logic               tx_done, tx_done_n;
  logic [31:0]        n_q, n_d;
  logic [IMEM_AW-1:0] widx, widx_d;
  logic               we_d;
  logic [IMEM_AW-1:0] waddr_d;
  logic [31:0]        wdata_d;
  logic [31:0]        word;
  logic               word_done;

  byte_packer u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pend),
    .in_byte   (uart_in),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_n   = state;
    n_d       = n_q;
    widx_d    = widx;
    tx_done_n = tx_done;
    we_d      = 1'b0;
    waddr_d   = imem_waddr;
    wdata_d   = imem_wdata;
    ld_rd     = 1'b0;
    ld_wr     = 1'b0;
    tx_byte   = 8'h00;
    unique case (state)
      LEN: begin
        ld_rd = ~pend & ~uart_empty;
        if (word_done) begin
          n_d = word;
          if (word == 32'd0)
            state_n = ACK;
          else if ({1'b0, word} > CAP)
            state_n = ERR;
          else
            state_n = DATA;
        end
      end
      DATA: begin
        ld_rd = ~pend & ~uart_empty;
        if (word_done) begin
          we_d    = 1'b1;
          waddr_d = widx;
          wdata_d = word;
          // Index stops at N-1 so it never wraps at full capacity.
          if (32'(widx) == n_q - 32'd1)
            state_n = ACK;
          else
            widx_d = widx + 1'b1;
        end
      end
      ACK: begin
        if (!uart_full) begin
          ld_wr   = 1'b1;
          tx_byte = ACK_BYTE;
          state_n = RUN;
        end
      end
      RUN: begin
      end
      ERR: begin
        if (!uart_full && !tx_done) begin
          ld_wr     = 1'b1;
          tx_byte   = NAK_BYTE;
          tx_done_n = 1'b1;
        end
      end
      default: state_n = LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LEN;
      pend       <= 1'b0;
      tx_done    <= 1'b0;
      n_q        <= 32'd0;
      widx       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
    end else begin
      state      <= state_n;
      pend       <= ld_rd;
      tx_done    <= tx_done_n;
      n_q        <= n_d;
      widx       <= widx_d;
      imem_we    <= we_d;
      imem_waddr <= waddr_d;
      imem_wdata <= wdata_d;
    end
  end

  assign cpu_run  = (state == RUN);
  assign load_err = (state == ERR);

  // Loader reads are gated by reset so the strobe is low while held.
  assign uart_rdreq     = cpu_run ? cpu_uart_rdreq : (rst_n & ld_rd);
  assign uart_wrreq     = cpu_run ? cpu_uart_wrreq : ld_wr;
  assign uart_out       = cpu_run ? cpu_uart_out : tx_byte;
  assign cpu_uart_empty = uart_empty | ~cpu_run;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader and UART owner for the single-core CPU. After reset it holds the CPU stopped, receives a length-prefixed program image over the shared UART byte FIFOs, writes it word by word into instruction memory and sends an acknowledge byte. It then releases the CPU and hands it the UART. It sits between the UART FIFOs and the CPU top level, and drives the instruction-memory write port.

## Interface
Parameters:
- IMEM_AW, 12, instruction-memory word-address width; capacity 2^IMEM_AW words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_empty  in  1  RX FIFO empty
- uart_in  in  8  RX FIFO data; valid the cycle after a uart_rdreq
- uart_full  in  1  TX FIFO full
- uart_rdreq  out  1  RX FIFO read strobe
- uart_wrreq  out  1  TX FIFO write strobe
- uart_out  out  8  TX FIFO data
- cpu_uart_rdreq  in  1  CPU read strobe; forwarded only in RUN
- cpu_uart_wrreq  in  1  CPU write strobe; forwarded only in RUN
- cpu_uart_out  in  8  CPU TX byte; forwarded only in RUN
- cpu_uart_empty  out  1  RX-empty as seen by the CPU, equal to uart_empty | ~cpu_run
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_waddr  out  IMEM_AW  word address
- imem_wdata  out  32  instruction word
- cpu_run  out  1  CPU may fetch/execute; PC must hold while 0
- load_err  out  1  sticky image-length error

## Operation
- Image format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
- RX read rule: at most one read in flight. uart_rdreq pulses for one cycle when uart_empty=0 and no byte is pending. uart_in is sampled in the next cycle, so there is at most one byte per 2 cycles.
- States:
  - LEN: collect 4 bytes into N.
    - N=0 → ACK.
    - N>2^IMEM_AW → ERR.
    - Otherwise → DATA.
  - DATA: assemble 4 bytes into a word. On the 4th byte, issue one imem_we with imem_waddr = word index (starts at 0, increments after each write). After word N-1 is written → ACK.
  - ACK: when uart_full=0, pulse uart_wrreq once with uart_out=8'h06 → RUN. While uart_full=1, stay in ACK with uart_wrreq=0.
  - RUN: cpu_run=1. uart_rdreq, uart_wrreq and uart_out mirror the cpu_uart_* inputs combinationally. The loader issues no reads or writes. RUN is terminal until reset.
  - ERR: load_err=1 and cpu_run=0. Send 8'h15 once, with the same uart_full rule as ACK. Then stay in ERR, reading nothing further.
- Outside RUN, all cpu_uart_* inputs are ignored.
- Width rules:
  - N is held in 32 bits; the comparison against 2^IMEM_AW uses the full 32 bits.
  - The word index counts 0..N-1 and never wraps. N = 2^IMEM_AW exactly is legal; the last address is all ones.

## Timing
- Reset values:
  - uart_rdreq, uart_wrreq, imem_we, cpu_run, load_err = 0.
  - uart_out, imem_waddr, imem_wdata = 0.
  - cpu_uart_empty = 1.
  - State = LEN; byte counters and word index = 0.
- Byte latency: rdreq in cycle k, sample in k+1. The next rdreq can be issued in k+2 at the earliest.
- Word write: imem_we/imem_waddr/imem_wdata are registered and asserted in the cycle after the 4th byte is sampled.
- ACK to RUN: cpu_run rises in the cycle after the uart_wrreq pulse.
- A load of N words with a never-empty FIFO completes in 8+8N cycles from reset release to the ACK pulse, assuming uart_full=0.
- Reset mid-operation (any state): everything returns to the reset values immediately. Partially written instruction memory is not cleared. The next image restarts from LEN.
- uart_empty rising while a byte is pending has no effect; the pending byte is still sampled.

## Structure
- Shared package loader_pkg:
  - state enum {LEN, DATA, ACK, RUN, ERR}
  - ACK_BYTE = 8'h06, NAK_BYTE = 8'h15
  - LEN_BYTES = 4
- Sub-module byte_packer: 4-byte little-endian shift/assemble with a 2-bit byte count and a word_done pulse. It is used for both N and the data words.
- The FSM, read-pending flag, word index and UART mux stay in prog_loader.

## Test plan
- N=2, words 0x00000013, 0x00100093, FIFO always non-empty:
  - imem_we at addresses 0 and 1 with those data values.
  - uart_out=0x06 once.
  - cpu_run=1 at cycle 25 after reset release.
- N=0: no imem_we; 0x06 sent; cpu_run rises.
- N=2^IMEM_AW+1 (0x00001001 at the default):
  - load_err=1, 0x15 sent once.
  - cpu_run stays 0 and uart_rdreq stays 0 afterwards.
- N=1 with gaps in uart_empty and uart_full=1 for 10 cycles at ACK:
  - word written correctly.
  - uart_wrreq held 0 until uart_full falls, then a single pulse.
- rst_n asserted after 5 of 8 data bytes:
  - outputs return to reset values asynchronously.
  - a fresh N=1 image then loads at address 0.
- In RUN, toggle cpu_uart_wrreq with cpu_uart_out=0x41 and cpu_uart_rdreq:
  - mirrored on uart_wrreq, uart_out and uart_rdreq in the same cycle.
  - cpu_uart_empty tracks uart_empty.
